// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, imem req/ack handshake, holding buffer and IF/ID register.
// Optional perf counters (perf_fetched / perf_bubbles) are built when FETCH_PERF_CNT_EN is defined.
module fetch_stage #(
  parameter int unsigned          ADDR_W    = 64,
  parameter int unsigned          INSTR_W   = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC  = '0,
  parameter logic [INSTR_W-1:0]   NOP_INSTR = 32'h00000013
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic               pc_write,
  input  logic               enable__IF_ID,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instruction__IF_ID,
  output logic [ADDR_W-1:0]  pc__IF_ID,
  output logic               valid__IF_ID,
  output logic               fetch_busy
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_bubbles
`endif
);

  typedef enum logic [1:0] {StIssue, StWait, StDrain} state_e;

  state_e               r_state;
  state_e               w_state_nxt;
  logic [ADDR_W-1:0]    r_pc;
  logic [ADDR_W-1:0]    w_pc_nxt;
  logic [ADDR_W-1:0]    r_req_addr;
  logic                 r_buf_valid;
  logic [INSTR_W-1:0]   r_buf_instr;
  logic [ADDR_W-1:0]    r_buf_pc;
  logic [INSTR_W-1:0]   r_ifid_instr;
  logic [ADDR_W-1:0]    r_ifid_pc;
  logic                 r_ifid_valid;

  logic                 w_issue;
  logic                 w_ack_wait;
  logic                 w_advance;
  logic                 w_deliver_mem;
  logic                 w_deliver_buf;
  logic                 w_capture;
  logic                 w_load;
  logic [INSTR_W-1:0]   w_load_instr;
  logic [ADDR_W-1:0]    w_load_pc;

  // Request is combinational in ISSUE so a 1-cycle ack gives one instruction per 2 cycles.
  assign w_issue       = (r_state == StIssue) && !r_buf_valid && !branch_taken && arst_n;
  assign w_ack_wait    = (r_state == StWait) && imem_ack;
  assign w_advance     = pc_write && enable__IF_ID;
  assign w_deliver_mem = w_ack_wait && !branch_taken && w_advance;
  assign w_capture     = w_ack_wait && !branch_taken && !w_advance;
  assign w_deliver_buf = (r_state == StIssue) && r_buf_valid && !branch_taken && w_advance;
  assign w_load        = w_deliver_mem || w_deliver_buf;
  assign w_load_instr  = w_deliver_buf ? r_buf_instr : imem_rdata;
  assign w_load_pc     = w_deliver_buf ? r_buf_pc : r_req_addr;

  assign imem_req           = w_issue || (r_state != StIssue);
  assign imem_addr          = (r_state == StIssue) ? r_pc : r_req_addr;
  assign fetch_busy         = (r_state != StIssue);
  assign instruction__IF_ID = r_ifid_instr;
  assign pc__IF_ID          = r_ifid_pc;
  assign valid__IF_ID       = r_ifid_valid;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    unique case (r_state)
      StIssue: begin
        if (branch_taken) begin
          w_pc_nxt = branch_target;
        end else if (w_issue) begin
          w_state_nxt = StWait;
        end else if (w_deliver_buf) begin
          w_pc_nxt = r_buf_pc + ADDR_W'(4);
        end
      end
      StWait: begin
        if (imem_ack) begin
          w_state_nxt = StIssue;
          if (branch_taken) begin
            w_pc_nxt = branch_target;
          end else if (w_deliver_mem) begin
            w_pc_nxt = r_req_addr + ADDR_W'(4);
          end
        end else if (branch_taken) begin
          // Request cannot be cancelled; wait out its ack before re-issuing.
          w_pc_nxt    = branch_target;
          w_state_nxt = StDrain;
        end
      end
      StDrain: begin
        if (branch_taken) begin
          w_pc_nxt = branch_target;
        end
        if (imem_ack) begin
          w_state_nxt = StIssue;
        end
      end
      default: begin
        w_state_nxt = StIssue;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      r_state      <= StIssue;
      r_pc         <= RESET_PC;
      r_req_addr   <= RESET_PC;
      r_buf_valid  <= 1'b0;
      r_buf_instr  <= NOP_INSTR;
      r_buf_pc     <= '0;
      r_ifid_instr <= NOP_INSTR;
      r_ifid_pc    <= '0;
      r_ifid_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_issue) begin
        r_req_addr <= r_pc;
      end
      if (branch_taken || w_deliver_buf) begin
        r_buf_valid <= 1'b0;
      end else if (w_capture) begin
        r_buf_valid <= 1'b1;
        r_buf_instr <= imem_rdata;
        r_buf_pc    <= r_req_addr;
      end
      if (branch_taken) begin
        r_ifid_instr <= NOP_INSTR;
        r_ifid_pc    <= '0;
        r_ifid_valid <= 1'b0;
      end else if (enable__IF_ID) begin
        if (w_load) begin
          r_ifid_instr <= w_load_instr;
          r_ifid_pc    <= w_load_pc;
          r_ifid_valid <= 1'b1;
        end else begin
          r_ifid_instr <= NOP_INSTR;
          r_ifid_valid <= 1'b0;
        end
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_bubbles;

  assign perf_fetched = r_perf_fetched;
  assign perf_bubbles = r_perf_bubbles;

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      r_perf_fetched <= '0;
      r_perf_bubbles <= '0;
    end else if (enable__IF_ID) begin
      if (w_load) begin
        if (r_perf_fetched != 32'hFFFF_FFFF) r_perf_fetched <= r_perf_fetched + 32'd1;
      end else begin
        if (r_perf_bubbles != 32'hFFFF_FFFF) r_perf_bubbles <= r_perf_bubbles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage: owns the PC register, issues requests to instruction memory over a req/ack handshake, and drives the IF/ID pipeline register.
- Consumes the hazard unit's pc_write / enable__IF_ID stall controls and the EX-stage branch redirect.
- Produces instruction__IF_ID / pc__IF_ID for decode, which the hazard unit compares against ID/EX.

Parameters:
- ADDR_W, 64, PC and instruction-memory address width.
- INSTR_W, 32, instruction width.
- RESET_PC, 0, PC value loaded at reset.
- NOP_INSTR, 32'h00000013, bubble instruction (addi x0,x0,0).

Ports:
- clk  input  1  clock, all state on rising edge.
- arst_n  input  1  reset, synchronous, active-low (sampled only on rising clk).
- pc_write  input  1  hazard unit: 0 freezes PC advance.
- enable__IF_ID  input  1  hazard unit: 0 holds the IF/ID register.
- branch_taken  input  1  redirect request from EX.
- branch_target  input  ADDR_W  redirect PC.
- imem_req  output  1  request valid.
- imem_addr  output  ADDR_W  request address, stable while imem_req=1 and no ack.
- imem_ack  input  1  response valid, one cycle, at least 1 cycle after req.
- imem_rdata  input  INSTR_W  instruction, valid with imem_ack.
- instruction__IF_ID  output  INSTR_W  registered instruction to decode.
- pc__IF_ID  output  ADDR_W  PC of instruction__IF_ID.
- valid__IF_ID  output  1  1 = real instruction, 0 = bubble.
- fetch_busy  output  1  1 while a request is outstanding or a redirect is being drained.

Behaviour:
- Reset (arst_n=0 at edge):
  - pc=RESET_PC; state=ISSUE; imem_req=0.
  - instruction__IF_ID=NOP_INSTR; pc__IF_ID=0; valid__IF_ID=0; holding buffer empty.
- State ISSUE:
  - If the buffer is empty, assert imem_req with imem_addr=pc (registered into req_addr); next state WAIT.
  - If branch_taken is high in the same cycle, pc<=branch_target and no request is issued.
- State WAIT: imem_req=1, imem_addr=req_addr (held).
  - On imem_ack with branch_taken=0:
    - If pc_write=1 and enable__IF_ID=1: load IF/ID with {rdata, req_addr, valid=1}; pc<=req_addr+4 (mod 2^ADDR_W, wraps); next state ISSUE.
    - Otherwise: capture rdata/req_addr into the holding buffer; pc unchanged; next state ISSUE, which does not issue while the buffer is full.
  - On imem_ack with branch_taken=1: discard rdata; pc<=branch_target; next state ISSUE.
  - branch_taken without imem_ack: pc<=branch_target; next state DRAIN. The request is non-cancellable, so imem_addr stays req_addr.
- State DRAIN: imem_req=1 until imem_ack. Discard rdata; next state ISSUE.
  - A second branch_taken in DRAIN overwrites pc (last redirect wins).
- Holding buffer:
  - When full, enable__IF_ID=1 and pc_write=1: IF/ID<=buffer, buffer emptied, pc<=buffer_pc+4.
  - branch_taken empties the buffer (contents dropped).
- IF/ID register update, priority order:
  1. arst_n=0.
  2. branch_taken=1 → flush: instruction=NOP_INSTR, valid=0, pc__IF_ID=0.
  3. enable__IF_ID=0 → hold all three outputs.
  4. No instruction available this cycle → bubble: NOP_INSTR, valid=0.
  5. Otherwise load.
- fetch_busy=1 in WAIT and DRAIN, 0 in ISSUE.
- Throughput: best case one instruction per 2 cycles with a 1-cycle ack. No instruction is ever delivered twice or skipped.
- Reset mid-request: state returns to ISSUE immediately. An ack arriving in the first post-reset cycle is ignored because state is not WAIT.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_fetched (32) and perf_bubbles (32).
  - perf_fetched increments on every IF/ID load with valid=1.
  - perf_bubbles increments on every IF/ID update with valid=0 (bubble or flush).
  - Both reset to 0, saturate at 32'hFFFFFFFF and hold when enable__IF_ID=0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release with RESET_PC=0x100, ack 1 cycle after req → imem_addr sequence 0x100, 0x104, 0x108; valid__IF_ID pulses each delivered instruction with matching pc__IF_ID.
- Stall: hold enable__IF_ID=0 and pc_write=0 for 3 cycles while ack 0xDEADBEEF arrives at pc 0x104 → IF/ID frozen on the previous instruction; 0xDEADBEEF appears one cycle after release; next imem_addr=0x108; no duplicate.
- branch_taken with target 0x200 while WAIT on addr 0x10C, ack 2 cycles later → imem_addr stays 0x10C until ack; rdata dropped; next request 0x200; IF/ID shows NOP_INSTR with valid=0 on the redirect cycle.
- branch_taken coincident with imem_ack → rdata dropped, next imem_addr=target, no stale instruction reaches decode.
- arst_n=0 asserted while WAIT → next cycle imem_req=0, pc=RESET_PC, valid__IF_ID=0; a late ack is ignored.
- With FETCH_PERF_CNT_EN defined, 5 fetches plus 1 flush → perf_fetched=5, perf_bubbles counts flush and bubble cycles exactly.
- PC=0xFFFF_FFFF_FFFF_FFFC fetch → next imem_addr=0 (wrap).
